// File: rtl/hs_arbiter_pkg.sv
// Shared definitions for the handshake arbiter family: state encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hs_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 8;

  // Encoding is fixed so that software-visible debug taps stay stable across revisions.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACK_UP = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/hs_arbiter_if.sv
// Bundles the upstream sender handshakes and the downstream receiver handshake.
// Latency: n/a (wires only).
// Backpressure: 4-phase req/ack in both directions; the arbiter is the only downstream master.
interface hs_arbiter_if #(
  parameter int N_REQ  = hs_pkg::DEF_N_REQ,
  parameter int DATA_W = hs_pkg::DEF_DATA_W,
  parameter int GID_W  = $clog2(N_REQ)
) ();

  logic [N_REQ-1:0]        req_in;
  logic [N_REQ*DATA_W-1:0] data_in;
  logic [N_REQ-1:0]        ack_out;
  logic                    req_out;
  logic [DATA_W-1:0]       data_out;
  logic                    ack_in;
  logic [GID_W-1:0]        grant_id;
  logic                    busy;
  logic [15:0]             xfer_count;

  // Arbiter side.
  modport master (
    input  req_in, data_in, ack_in,
    output ack_out, req_out, data_out, grant_id, busy, xfer_count
  );

  // Environment side: senders plus the downstream receiver.
  modport slave (
    output req_in, data_in, ack_in,
    input  ack_out, req_out, data_out, grant_id, busy, xfer_count
  );

endinterface

// File: rtl/hs_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N_REQ.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is consumed.
module rr_pick #(
  parameter int N_REQ = hs_pkg::DEF_N_REQ,
  parameter int GID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] ptr,
  output logic             valid,
  output logic [GID_W-1:0] winner
);

  localparam logic [GID_W:0] N_WIDE = (GID_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [GID_W-1:0]   offset;
  logic [GID_W:0]     sum;

  // Rotating right by ptr puts the highest-priority requester at bit 0.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N_REQ];
  assign valid   = |req;

  // Priority-encode the rotated vector: lowest set bit wins.
  always_comb begin
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = GID_W'(i);
    end
  end

  // Un-rotate: add ptr back and fold into 0..N_REQ-1 (N_REQ need not be a power of two).
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= N_WIDE) sum = sum - N_WIDE;
    winner = sum[GID_W-1:0];
  end

endmodule

// File: rtl/hs_arbiter.sv
// Shares one 4-phase receiver among N_REQ senders with round-robin grant and a transfer counter.
// Latency: req_in -> req_out 1 clk; ack_in -> ack_out 1 clk; DONE adds one dead cycle per transfer.
// Backpressure: losers hold req_in until granted; the downstream receiver paces via ack_in.
module hs_arbiter
  import hs_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int GID_W  = $clog2(N_REQ)
) (
  input  logic         clk,
  input  logic         reset,
  hs_arbiter_if.master bus
);

  state_t            state_q,      state_d;
  logic [GID_W-1:0]  ptr_q,        ptr_d;
  logic              req_out_q,    req_out_d;
  logic [N_REQ-1:0]  ack_out_q,    ack_out_d;
  logic [DATA_W-1:0] data_out_q,   data_out_d;
  logic [GID_W-1:0]  grant_id_q,   grant_id_d;
  logic              busy_q,       busy_d;
  logic [15:0]       xfer_count_q, xfer_count_d;

  logic              pick_vld;
  logic [GID_W-1:0]  pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .GID_W (GID_W)
  ) u_rr_pick (
    .req    (bus.req_in),
    .ptr    (ptr_q),
    .valid  (pick_vld),
    .winner (pick_idx)
  );

  // Register stage: every output comes straight from a flop; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      req_out_q    <= 1'b0;
      ack_out_q    <= '0;
      data_out_q   <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      req_out_q    <= req_out_d;
      ack_out_q    <= ack_out_d;
      data_out_q   <= data_out_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  // Next-state and next-output logic for the grant / downstream / release / retire sequence.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    req_out_d    = req_out_q;
    ack_out_d    = ack_out_q;
    data_out_d   = data_out_q;
    grant_id_d   = grant_id_q;
    busy_d       = busy_q;
    xfer_count_d = xfer_count_q;

    unique case (state_q)
      IDLE: begin
        // A lingering downstream ack means the receiver has not finished its own
        // return-to-zero; starting a new request now would alias with it.
        if (pick_vld && !bus.ack_in) begin
          data_out_d = bus.data_in[pick_idx*DATA_W +: DATA_W];
          grant_id_d = pick_idx;
          req_out_d  = 1'b1;
          busy_d     = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        // A sender dropping req early is ignored: the receiver already owns the data.
        if (bus.ack_in) begin
          req_out_d             = 1'b0;
          ack_out_d             = '0;
          ack_out_d[grant_id_q] = 1'b1;
          state_d               = ACK_UP;
        end
      end
      ACK_UP: begin
        // Both sides must have returned to zero on the same edge, in whatever order.
        if (!bus.ack_in && !bus.req_in[grant_id_q]) begin
          ack_out_d = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        ptr_d        = (grant_id_q == GID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        xfer_count_d = xfer_count_q + 16'd1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_out    = req_out_q;
  assign bus.ack_out    = ack_out_q;
  assign bus.data_out   = data_out_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = busy_q;
  assign bus.xfer_count = xfer_count_q;

endmodule

// File: tb/tb_hs_arbiter.sv
// Self-checking bench for hs_arbiter: vector table, directed multi-cycle sequences, random run.
// Latency: n/a.
// Backpressure: n/a.
module tb_hs_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hs_arbiter_if #(.N_REQ(N), .DATA_W(W), .GID_W(2)) bus ();

  hs_arbiter #(.N_REQ(N), .DATA_W(W), .GID_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (transaction view) ----------------
  // phase: 0 waiting for a grant, 1 downstream request open, 2 sender being acked, 3 retiring
  int         m_phase, m_ptr, m_gid, m_cnt;
  logic       m_ro, m_busy;
  logic [3:0] m_ao;
  logic [7:0] m_dout;

  task automatic model_update(input logic rst, input logic [3:0] req, input logic ack,
                              input logic [31:0] din);
    bit found;
    int idx;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_gid = 0; m_cnt = 0;
      m_ro = 0; m_busy = 0; m_ao = 0; m_dout = 0;
    end else begin
      case (m_phase)
        0: if (req != 0 && !ack) begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && req[idx]) begin
              found = 1;
              m_gid = idx;
            end
          end
          m_dout = din[m_gid*W +: W];
          m_ro = 1; m_busy = 1; m_phase = 1;
        end
        1: if (ack) begin
          m_ro = 0; m_ao = 4'(1 << m_gid); m_phase = 2;
        end
        2: if (!ack && !req[m_gid]) begin
          m_ao = 0; m_phase = 3;
        end
        default: begin
          m_ptr = (m_gid + 1) % N;
          m_cnt = (m_cnt + 1) % 65536;
          m_busy = 0; m_phase = 0;
        end
      endcase
    end
  endtask

  function automatic logic [31:0] pack_out(input logic ro, input logic [3:0] ao,
      input logic [7:0] d, input logic [1:0] g, input logic b, input logic [15:0] c);
    return {ro, ao, d, g, b, c};
  endfunction

  function automatic logic [31:0] dut_vec();
    return pack_out(bus.req_out, bus.ack_out, bus.data_out, bus.grant_id, bus.busy,
                    bus.xfer_count);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model consumes the same inputs the DUT samples, then both are compared.
  task automatic step();
    model_update(reset, bus.req_in, bus.ack_in, bus.data_in);
    @(posedge clk);
    #1;
    chk("model", dut_vec(),
        pack_out(m_ro, m_ao, m_dout, 2'(m_gid), m_busy, 16'(m_cnt)));
    chk("ack_onehot", 32'($countones(bus.ack_out) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1; bus.req_in = 0; bus.ack_in = 0;
    step();
    reset = 0;
  endtask

  // Full transfer for whichever sender wins; the winner releases req, others keep theirs.
  task automatic xfer(output int gid, output logic [7:0] d);
    int n;
    gid = -1; d = 0;
    n = 0;
    while (!bus.req_out && n < 30) begin step(); n++; end
    if (!bus.req_out) begin
      errors++; $display("FAIL xfer_req_timeout actual 0 required 1"); return;
    end
    gid = int'(bus.grant_id); d = bus.data_out;
    bus.ack_in = 1;
    n = 0;
    while (bus.ack_out == 0 && n < 30) begin step(); n++; end
    if (bus.ack_out == 0) begin
      errors++; $display("FAIL xfer_ack_timeout actual 0 required nonzero"); return;
    end
    bus.req_in[gid] = 0;
    bus.ack_in = 0;
    n = 0;
    while (bus.busy && n < 30) begin step(); n++; end
    if (bus.busy) begin
      errors++; $display("FAIL xfer_busy_timeout actual 1 required 0");
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        ack;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[23];

  initial begin
    int         gid;
    logic [7:0] d;

    checks = 0; errors = 0;
    reset = 1; bus.req_in = 0; bus.ack_in = 0; bus.data_in = 32'h4332213C;

    // rst, req, ack -> req_out, ack_out, data_out, grant_id, busy, xfer_count
    tbl[0]  = '{1, 4'h0, 0, pack_out(0, 4'h0, 8'h00, 0, 0, 0)};
    tbl[1]  = '{0, 4'h1, 0, pack_out(1, 4'h0, 8'h3C, 0, 1, 0)};
    tbl[2]  = '{0, 4'h1, 0, pack_out(1, 4'h0, 8'h3C, 0, 1, 0)};
    tbl[3]  = '{0, 4'h1, 0, pack_out(1, 4'h0, 8'h3C, 0, 1, 0)};
    tbl[4]  = '{0, 4'h1, 1, pack_out(0, 4'h1, 8'h3C, 0, 1, 0)};
    tbl[5]  = '{0, 4'h0, 1, pack_out(0, 4'h1, 8'h3C, 0, 1, 0)};
    tbl[6]  = '{0, 4'h0, 0, pack_out(0, 4'h0, 8'h3C, 0, 1, 0)};
    tbl[7]  = '{0, 4'h0, 0, pack_out(0, 4'h0, 8'h3C, 0, 0, 1)};
    tbl[8]  = '{0, 4'h2, 1, pack_out(0, 4'h0, 8'h3C, 0, 0, 1)};
    tbl[9]  = '{0, 4'h2, 1, pack_out(0, 4'h0, 8'h3C, 0, 0, 1)};
    tbl[10] = '{0, 4'h2, 0, pack_out(1, 4'h0, 8'h21, 1, 1, 1)};
    tbl[11] = '{0, 4'h2, 1, pack_out(0, 4'h2, 8'h21, 1, 1, 1)};
    tbl[12] = '{0, 4'h0, 0, pack_out(0, 4'h0, 8'h21, 1, 1, 1)};
    tbl[13] = '{0, 4'h0, 0, pack_out(0, 4'h0, 8'h21, 1, 0, 2)};
    tbl[14] = '{0, 4'h1, 0, pack_out(1, 4'h0, 8'h3C, 0, 1, 2)};
    tbl[15] = '{0, 4'h1, 1, pack_out(0, 4'h1, 8'h3C, 0, 1, 2)};
    tbl[16] = '{1, 4'h1, 1, pack_out(0, 4'h0, 8'h00, 0, 0, 0)};
    tbl[17] = '{0, 4'h5, 0, pack_out(1, 4'h0, 8'h3C, 0, 1, 0)};
    tbl[18] = '{0, 4'h5, 1, pack_out(0, 4'h1, 8'h3C, 0, 1, 0)};
    tbl[19] = '{0, 4'h4, 1, pack_out(0, 4'h1, 8'h3C, 0, 1, 0)};
    tbl[20] = '{0, 4'h4, 0, pack_out(0, 4'h0, 8'h3C, 0, 1, 0)};
    tbl[21] = '{0, 4'h4, 0, pack_out(0, 4'h0, 8'h3C, 0, 0, 1)};
    tbl[22] = '{0, 4'h4, 0, pack_out(1, 4'h0, 8'h32, 2, 1, 1)};

    for (int i = 0; i < 23; i++) begin
      reset = tbl[i].rst; bus.req_in = tbl[i].req; bus.ack_in = tbl[i].ack;
      step();
      chk($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
    end

    // All four request together: grants walk 0,1,2,3.
    bus.data_in = 32'h43322110;
    do_reset();
    bus.req_in = 4'hF;
    for (int k = 0; k < 4; k++) begin
      xfer(gid, d);
      chk($sformatf("all4_gid%0d", k), 32'(gid), 32'(k));
      chk($sformatf("all4_data%0d", k), {24'h0, d}, 32'(8'h10 + 8'h11 * k));
    end
    chk("all4_count", {16'h0, bus.xfer_count}, 32'd4);

    // Rotation: after sender 2, pointer sits at 3 and wraps to 0 before 2 again.
    do_reset();
    bus.req_in = 4'b0100;
    xfer(gid, d);
    chk("rot_first", 32'(gid), 32'd2);
    bus.req_in = 4'b0101;
    xfer(gid, d);
    chk("rot_wrap", 32'(gid), 32'd0);
    xfer(gid, d);
    chk("rot_second", 32'(gid), 32'd2);

    // Release order: ack_in falls first, then req_in[1] five clocks later; then the reverse.
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      bus.req_in = 4'b0010;
      for (int n = 0; n < 30 && !bus.req_out; n++) step();
      bus.ack_in = 1;
      for (int n = 0; n < 30 && bus.ack_out == 0; n++) step();
      if (pass == 0) bus.ack_in = 0; else bus.req_in = 0;
      for (int n = 0; n < 5; n++) begin
        step();
        chk($sformatf("order%0d_hold", pass), {28'h0, bus.ack_out}, 32'h2);
      end
      if (pass == 0) bus.req_in = 0; else bus.ack_in = 0;
      step();
      chk($sformatf("order%0d_done", pass), {27'h0, bus.ack_out, bus.busy}, 32'h1);
      step();
      chk($sformatf("order%0d_idle", pass), {15'h0, bus.busy, bus.xfer_count},
          32'(pass + 1));
    end

    // Random traffic, including protocol violations and occasional resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      bus.req_in   = 4'($urandom_range(0, 15));
      bus.ack_in   = ($urandom_range(0, 2) == 0);
      bus.data_in  = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
